fetch_pc_unit: RTL and testbench

//   Program-counter and fetch-address stage of the MIPS150 pipeline. Consumes

---
 rtl/fetch_pc_unit.sv | 119 +++++++++++
 tb/tb_fetch_pc_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter / fetch-address stage with MIPS delay-slot redirects.
// The fetch that is in flight (or completing) when a transfer is accepted is
// the delay slot and is always delivered; the target is fetched after it.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_RUN  | sequential fetch; a redirect applies on the completing edge
//   ST_PEND | transfer accepted mid-request; target held until completion
`timescale 1ns/1ps

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        x_valid,
  input  logic        take_branch,
  input  logic [5:0]  x_opcode,
  input  logic [5:0]  x_funct,
  input  logic [31:0] x_pc,
  input  logic [15:0] x_imm,
  input  logic [25:0] x_jidx,
  input  logic [31:0] x_rs_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic [31:0] f_pc,
  output logic        f_valid,
  output logic        redirect
);

  typedef enum logic {ST_RUN, ST_PEND} state_t;

  state_t      state;
  logic [31:0] pend_target;
  logic [31:0] target;
  logic        legal;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic        complete;
  logic        accept;

  assign pc_plus4 = x_pc + 32'd4;
  assign br_off   = {{14{x_imm[15]}}, x_imm, 2'b00};
  assign complete = imem_req & imem_ready & ~stall;
  assign accept   = x_valid & take_branch & ~stall & legal;

  // Transfer target decode; opcodes outside the branch/jump set never redirect.
  always_comb begin
    target = '0;
    legal  = 1'b0;
    case (x_opcode)
      6'd1, 6'd4, 6'd5, 6'd6, 6'd7: begin
        target = pc_plus4 + br_off;
        legal  = 1'b1;
      end
      6'd2, 6'd3: begin
        target = {pc_plus4[31:28], x_jidx, 2'b00};
        legal  = 1'b1;
      end
      6'd0: begin
        if (x_funct == 6'h08 || x_funct == 6'h09) begin
          target = {x_rs_val[31:2], 2'b00};
          legal  = 1'b1;
        end
      end
      default: begin
        target = '0;
        legal  = 1'b0;
      end
    endcase
  end

  // Fetch handshake, redirect FSM and decode-side PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      pend_target <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      f_pc        <= '0;
      f_valid     <= 1'b0;
      redirect    <= 1'b0;
    end else begin
      imem_req <= 1'b1;
      redirect <= 1'b0;
      if (complete) begin
        f_pc    <= imem_addr;
        f_valid <= 1'b1;
      end
      case (state)
        ST_RUN: begin
          if (complete) begin
            if (accept) begin
              imem_addr <= target;
              redirect  <= 1'b1;
            end else begin
              imem_addr <= imem_addr + 32'd4;
            end
          end else if (accept) begin
            pend_target <= target;
            state       <= ST_PEND;
          end
        end
        ST_PEND: begin
          // A second accept here is dropped: only one transfer per delay slot.
          if (complete) begin
            imem_addr <= pend_target;
            redirect  <= 1'b1;
            state     <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, branch/jump/jr redirects,
// pending redirect over imem wait states, stall freeze and reset in PEND.
`timescale 1ns/1ps

module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        x_valid = 1'b0;
  logic        take_branch = 1'b0;
  logic [5:0]  x_opcode = '0;
  logic [5:0]  x_funct = '0;
  logic [31:0] x_pc = '0;
  logic [15:0] x_imm = '0;
  logic [25:0] x_jidx = '0;
  logic [31:0] x_rs_val = '0;
  logic        imem_ready = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        redirect;

  int checks = 0;
  int failures = 0;

  fetch_pc_unit #(.RESET_PC(32'h4000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .x_valid(x_valid),
    .take_branch(take_branch), .x_opcode(x_opcode), .x_funct(x_funct),
    .x_pc(x_pc), .x_imm(x_imm), .x_jidx(x_jidx), .x_rs_val(x_rs_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .f_pc(f_pc), .f_valid(f_valid), .redirect(redirect)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_xfer(input logic [5:0] opc, input logic [5:0] fn,
                            input logic [31:0] pc, input logic [15:0] imm,
                            input logic [25:0] jidx, input logic [31:0] rs);
    x_valid = 1'b1; take_branch = 1'b1; x_opcode = opc; x_funct = fn;
    x_pc = pc; x_imm = imm; x_jidx = jidx; x_rs_val = rs;
  endtask

  task automatic clear_xfer();
    x_valid = 1'b0; take_branch = 1'b0; x_opcode = '0; x_funct = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (imem_addr !== 32'h4000_0000) begin failures++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h4000_0000); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (f_valid !== 1'b0 || f_pc !== 32'h0) begin failures++; $display("FAIL rst_f got=%b/%h exp=0/0", f_valid, f_pc); end
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%b exp=0", redirect); end
    rst = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0000 || f_valid !== 1'b0) begin failures++; $display("FAIL first_req got=%b/%h/%b exp=1/40000000/0", imem_req, imem_addr, f_valid); end
    step();
    checks++; if (imem_addr !== 32'h4000_0004 || f_pc !== 32'h4000_0000 || f_valid !== 1'b1) begin failures++; $display("FAIL seq1 got=%h/%h/%b exp=40000004/40000000/1", imem_addr, f_pc, f_valid); end
    step();
    checks++; if (imem_addr !== 32'h4000_0008 || f_pc !== 32'h4000_0004) begin failures++; $display("FAIL seq2 got=%h/%h exp=40000008/40000004", imem_addr, f_pc); end
  endtask

  task automatic test_beq();
    step(); step(); step();
    checks++; if (imem_addr !== 32'h4000_0014) begin failures++; $display("FAIL beq_pre got=%h exp=40000014", imem_addr); end
    drive_xfer(6'd4, 6'd0, 32'h4000_0010, 16'hFFFC, 26'h0, 32'h0);
    step();
    clear_xfer();
    checks++; if (imem_addr !== 32'h4000_0004 || redirect !== 1'b1 || f_pc !== 32'h4000_0014) begin failures++; $display("FAIL beq_redir got=%h/%b/%h exp=40000004/1/40000014", imem_addr, redirect, f_pc); end
    step();
    checks++; if (imem_addr !== 32'h4000_0008 || redirect !== 1'b0 || f_pc !== 32'h4000_0004) begin failures++; $display("FAIL beq_after got=%h/%b/%h exp=40000008/0/40000004", imem_addr, redirect, f_pc); end
  endtask

  task automatic test_jump();
    drive_xfer(6'd2, 6'd0, 32'h4FFF_FFFC, 16'h0, 26'h000_0010, 32'h0);
    step();
    clear_xfer();
    checks++; if (imem_addr !== 32'h5000_0040 || redirect !== 1'b1 || f_pc !== 32'h4000_0008) begin failures++; $display("FAIL j_redir got=%h/%b/%h exp=50000040/1/40000008", imem_addr, redirect, f_pc); end
    step();
    checks++; if (imem_addr !== 32'h5000_0044 || redirect !== 1'b0 || f_pc !== 32'h5000_0040) begin failures++; $display("FAIL j_after got=%h/%b/%h exp=50000044/0/50000040", imem_addr, redirect, f_pc); end
  endtask

  task automatic test_jr_pend();
    imem_ready = 1'b0;
    drive_xfer(6'd0, 6'h08, 32'h0, 16'h0, 26'h0, 32'h4000_0123);
    step();
    checks++; if (imem_addr !== 32'h5000_0044 || redirect !== 1'b0 || f_pc !== 32'h5000_0040) begin failures++; $display("FAIL jr_hold0 got=%h/%b/%h exp=50000044/0/50000040", imem_addr, redirect, f_pc); end
    // A second transfer while pending must be dropped.
    drive_xfer(6'd4, 6'd0, 32'h4000_0000, 16'h0004, 26'h0, 32'h0);
    step();
    clear_xfer();
    step();
    checks++; if (imem_addr !== 32'h5000_0044 || redirect !== 1'b0) begin failures++; $display("FAIL jr_hold2 got=%h/%b exp=50000044/0", imem_addr, redirect); end
    imem_ready = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h4000_0120 || redirect !== 1'b1 || f_pc !== 32'h5000_0044) begin failures++; $display("FAIL jr_redir got=%h/%b/%h exp=40000120/1/50000044", imem_addr, redirect, f_pc); end
    step();
    checks++; if (imem_addr !== 32'h4000_0124 || redirect !== 1'b0 || f_pc !== 32'h4000_0120) begin failures++; $display("FAIL jr_after got=%h/%b/%h exp=40000124/0/40000120", imem_addr, redirect, f_pc); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    drive_xfer(6'd5, 6'd0, 32'h4000_0200, 16'h0010, 26'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (imem_addr !== 32'h4000_0124 || f_pc !== 32'h4000_0120 || redirect !== 1'b0) begin failures++; $display("FAIL stall_%0d got=%h/%h/%b exp=40000124/40000120/0", i, imem_addr, f_pc, redirect); end
    end
    stall = 1'b0;
    step();
    clear_xfer();
    checks++; if (imem_addr !== 32'h4000_0244 || redirect !== 1'b1 || f_pc !== 32'h4000_0124) begin failures++; $display("FAIL stall_release got=%h/%b/%h exp=40000244/1/40000124", imem_addr, redirect, f_pc); end
    step();
    checks++; if (imem_addr !== 32'h4000_0248 || redirect !== 1'b0) begin failures++; $display("FAIL stall_after got=%h/%b exp=40000248/0", imem_addr, redirect); end
  endtask

  task automatic test_illegal();
    drive_xfer(6'h23, 6'd0, 32'h4000_0000, 16'h0100, 26'h0, 32'h1000_0000);
    step();
    checks++; if (imem_addr !== 32'h4000_024C || redirect !== 1'b0) begin failures++; $display("FAIL illegal_lw got=%h/%b exp=4000024c/0", imem_addr, redirect); end
    drive_xfer(6'd0, 6'h20, 32'h4000_0000, 16'h0100, 26'h0, 32'h1000_0000);
    step();
    clear_xfer();
    checks++; if (imem_addr !== 32'h4000_0250 || redirect !== 1'b0) begin failures++; $display("FAIL illegal_add got=%h/%b exp=40000250/0", imem_addr, redirect); end
  endtask

  task automatic test_wrap();
    drive_xfer(6'd1, 6'd0, 32'hFFFF_FFF8, 16'h0001, 26'h0, 32'h0);
    step();
    clear_xfer();
    checks++; if (imem_addr !== 32'h0000_0000 || redirect !== 1'b1) begin failures++; $display("FAIL wrap got=%h/%b exp=00000000/1", imem_addr, redirect); end
    step();
    checks++; if (imem_addr !== 32'h0000_0004 || f_pc !== 32'h0000_0000) begin failures++; $display("FAIL wrap_after got=%h/%h exp=00000004/00000000", imem_addr, f_pc); end
  endtask

  task automatic test_reset_pend();
    imem_ready = 1'b0;
    drive_xfer(6'd0, 6'h09, 32'h0, 16'h0, 26'h0, 32'h7000_0000);
    step();
    clear_xfer();
    checks++; if (imem_addr !== 32'h0000_0004 || redirect !== 1'b0) begin failures++; $display("FAIL rp_hold got=%h/%b exp=00000004/0", imem_addr, redirect); end
    rst = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h4000_0000 || imem_req !== 1'b0 || f_valid !== 1'b0 || f_pc !== 32'h0 || redirect !== 1'b0) begin failures++; $display("FAIL rp_async got=%h/%b/%b/%h/%b exp=40000000/0/0/0/0", imem_addr, imem_req, f_valid, f_pc, redirect); end
    step();
    rst = 1'b0;
    imem_ready = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h4000_0000 || imem_req !== 1'b1 || redirect !== 1'b0) begin failures++; $display("FAIL rp_restart got=%h/%b/%b exp=40000000/1/0", imem_addr, imem_req, redirect); end
    step();
    checks++; if (imem_addr !== 32'h4000_0004 || f_pc !== 32'h4000_0000 || redirect !== 1'b0) begin failures++; $display("FAIL rp_seq got=%h/%h/%b exp=40000004/40000000/0", imem_addr, f_pc, redirect); end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_jump();
    test_jr_pend();
    test_stall();
    test_illegal();
    test_wrap();
    test_reset_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
